wb_timer_slave: RTL

WB_TIMER_SLAVE -- requirements
Module: wb_timer_slave

---
 rtl/wb_timer_slave.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/wb_timer_slave.sv
// Wishbone slave with a 32-bit free-running timer: CTRL / COUNT / COMPARE / STATUS.
// The bus side is a three-state handshake (IDLE -> WAIT -> ACK) with a fixed,
// parameterised number of wait states. The timer compares COUNT against
// COMPARE and raises a sticky MATCH flag, optionally reloading COUNT to zero.
module wb_timer_slave #(
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wishbone_addr_i,
    input  logic [31:0] wishbone_data_i,
    input  logic        wishbone_we_i,
    input  logic [3:0]  wishbone_sel_i,
    input  logic        wishbone_stb_i,
    input  logic        wishbone_cyc_i,
    output logic [31:0] wishbone_data_o,
    output logic        wishbone_ack_o,
    output logic        irq_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    localparam logic [1:0] A_CTRL    = 2'd0;
    localparam logic [1:0] A_COUNT   = 2'd1;
    localparam logic [1:0] A_COMPARE = 2'd2;
    localparam logic [1:0] A_STATUS  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [1:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic        ack_q, ack_d;

    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        match_q, match_d;

    logic        wr_en;
    logic        hit;
    logic [31:0] rd_mux;
    logic        addr_unused;

    // Only address bits [3:2] select a register; the rest are don't-care.
    assign addr_unused = ^{wishbone_addr_i[31:4], wishbone_addr_i[1:0]};

    // Replace only the byte lanes whose select bit is set.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

    // Bus handshake: capture the request, count wait states, abort on a dropped strobe.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        sel_d   = sel_q;
        case (state_q)
            S_IDLE: begin
                if (wishbone_cyc_i && wishbone_stb_i) begin
                    addr_d  = wishbone_addr_i[3:2];
                    wdata_d = wishbone_data_i;
                    we_d    = wishbone_we_i;
                    sel_d   = wishbone_sel_i;
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        wcnt_d  = WAIT_LOAD;
                    end else begin
                        state_d = S_ACK;
                    end
                end
            end
            S_WAIT: begin
                if (!wishbone_cyc_i || !wishbone_stb_i) begin
                    state_d = S_IDLE;
                end else if (wcnt_q == 4'd0) begin
                    state_d = S_ACK;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The _d capture values hold the live request in IDLE and the captured one in
    // WAIT, so a write commits on the ACK-entry edge with either wait-state setting.
    assign wr_en = (state_d == S_ACK) && (state_q != S_ACK) && we_d;
    assign ack_d = (state_d == S_ACK);
    assign hit   = ctrl_q[0] && (count_q == compare_q);

    // Timer advance and bus writes; a bus write to COUNT overrides the timer,
    // and a new match overrides a same-cycle write-1-to-clear.
    always_comb begin
        ctrl_d    = ctrl_q;
        compare_d = compare_q;
        match_d   = match_q;
        count_d   = count_q;
        if (ctrl_q[0]) begin
            count_d = (hit && ctrl_q[2]) ? 32'd0 : count_q + 32'd1;
        end
        if (wr_en) begin
            case (addr_d)
                A_CTRL:    if (sel_d[0]) ctrl_d = wdata_d[2:0];
                A_COUNT:   count_d = merge_lanes(count_q, wdata_d, sel_d);
                A_COMPARE: compare_d = merge_lanes(compare_q, wdata_d, sel_d);
                A_STATUS:  if (sel_d[0] && wdata_d[0]) match_d = 1'b0;
                default:   ;
            endcase
        end
        if (hit) match_d = 1'b1;
    end

    // Read mux for the register addressed by the transfer currently in ACK.
    always_comb begin
        rd_mux = 32'd0;
        case (addr_q)
            A_CTRL:    rd_mux = {29'd0, ctrl_q};
            A_COUNT:   rd_mux = count_q;
            A_COMPARE: rd_mux = compare_q;
            A_STATUS:  rd_mux = {31'd0, match_q};
            default:   rd_mux = 32'd0;
        endcase
    end

    // Control and architectural state, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            wcnt_q    <= 4'd0;
            ack_q     <= 1'b0;
            ctrl_q    <= 3'd0;
            count_q   <= 32'd0;
            compare_q <= 32'hFFFF_FFFF;
            match_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            ack_q     <= ack_d;
            ctrl_q    <= ctrl_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            match_q   <= match_d;
        end
    end

    // Captured request fields; only meaningful while a transfer is in flight.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        we_q    <= we_d;
        sel_q   <= sel_d;
    end

    assign wishbone_ack_o  = ack_q;
    assign wishbone_data_o = ack_q ? rd_mux : 32'd0;
    assign irq_o           = match_q & ctrl_q[1];

endmodule
